// File: rtl/key_debounce_multi_if.sv
// Key debouncer bus: raw key inputs in, debounced level and event pulses out.
// Latency: none (signal bundle only).
// Backpressure: none; every output is a level or a one-clk pulse the consumer must catch.
//
// Signals (CH = number of key channels):
//   key_in      raw asynchronous key levels, bit i = channel i
//   key_state   debounced level, 1 = pressed
//   key_press   one-clk pulse on accepted released->pressed transition
//   key_release one-clk pulse on accepted pressed->released transition
//   key_long    one-clk pulse when pressed state has lasted the long-press time
//   tick_out    shared one-clk sample tick
// Modports: slave = debouncer side, master = key source / event consumer side.
interface key_debounce_multi_if #(
    parameter int CH = 4
);
    logic [CH-1:0] key_in;
    logic [CH-1:0] key_state;
    logic [CH-1:0] key_press;
    logic [CH-1:0] key_release;
    logic [CH-1:0] key_long;
    logic          tick_out;

    modport slave (
        input  key_in,
        output key_state,
        output key_press,
        output key_release,
        output key_long,
        output tick_out
    );

    modport master (
        output key_in,
        input  key_state,
        input  key_press,
        input  key_release,
        input  key_long,
        input  tick_out
    );
endinterface

// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: 2-flop sync, shared tick timebase, per-channel stability and long-press counters.
// Latency: 2 clk sync + STABLE_TICKS qualifying ticks (2+(STABLE_TICKS-1)*TICK_DIV+1 .. 2+STABLE_TICKS*TICK_DIV clk).
// Backpressure: none; pulses are one clk wide, registered, and only ever follow a tick edge.
//
// Ports:
//   clk    system clock, all flops rising-edge
//   rst_n  asynchronous active-low reset
//   bus    key_debounce_multi_if.slave: key_in in; key_state, key_press, key_release, key_long, tick_out out
module key_debounce_multi #(
    parameter int CH           = 4,
    parameter int TICK_DIV     = 240000,
    parameter int STABLE_TICKS = 2,
    parameter int LONG_TICKS   = 50,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    key_debounce_multi_if.slave  bus
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(STABLE_TICKS + 1);
    localparam int LW = $clog2(LONG_TICKS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_TICKS - 1);
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_TICKS);

    // Raw level a released key presents; the synchroniser resets to it so
    // leaving reset never looks like an edge.
    localparam logic [CH-1:0] REL_LVL = {CH{(ACTIVE_LOW != 0)}};

    logic [TW-1:0] tick_cnt;
    logic          tick;

    logic [CH-1:0] sync1;
    logic [CH-1:0] sync2;
    logic [CH-1:0] samp;
    logic [CH-1:0] diff;
    logic [CH-1:0] flip;

    logic [CH-1:0] state_q;
    logic [CH-1:0] press_q;
    logic [CH-1:0] release_q;
    logic [CH-1:0] long_q;

    logic [SW-1:0] stab_cnt [CH];
    logic [LW-1:0] long_cnt [CH];

    // ------------------------------------------------------------------
    // Shared tick: high for the single cycle the counter sits at TICK_DIV-1.
    // ------------------------------------------------------------------
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Synchroniser and polarity normalisation (samp: 1 = pressed).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= REL_LVL;
            sync2 <= REL_LVL;
        end else begin
            sync1 <= bus.key_in;
            sync2 <= sync1;
        end
    end

    assign samp = sync2 ^ REL_LVL;
    assign diff = samp ^ state_q;

    // A channel flips on the tick where a disagreeing sample arrives with
    // STABLE_TICKS-1 disagreeing ticks already counted.
    always_comb begin
        flip = '0;
        for (int i = 0; i < CH; i++) begin
            flip[i] = tick & diff[i] & (stab_cnt[i] == STAB_LAST);
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce state, long-press tracking and event pulses.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            for (int i = 0; i < CH; i++) begin
                stab_cnt[i] <= '0;
                long_cnt[i] <= '0;
            end
        end else begin
            state_q   <= state_q ^ flip;
            press_q   <= flip & ~state_q;
            release_q <= flip & state_q;
            long_q    <= '0;
            for (int i = 0; i < CH; i++) begin
                if (tick) begin
                    if (!diff[i] || flip[i]) begin
                        stab_cnt[i] <= '0;
                    end else begin
                        stab_cnt[i] <= stab_cnt[i] + SW'(1);
                    end
                end

                // Counter is held at 0 while released, so the edge that
                // accepts a press also leaves it at 0. The release tick does
                // not count, keeping key_long exclusive with key_release.
                if (!state_q[i]) begin
                    long_cnt[i] <= '0;
                end else if (tick && !flip[i] && (long_cnt[i] != LONG_MAX)) begin
                    long_cnt[i] <= long_cnt[i] + LW'(1);
                    if (long_cnt[i] == LONG_LAST) begin
                        long_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.key_state   = state_q;
    assign bus.key_press   = press_q;
    assign bus.key_release = release_q;
    assign bus.key_long    = long_q;
    assign bus.tick_out    = tick;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi with CH=2, TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=5, ACTIVE_LOW=1.
// Inputs are driven just after a falling edge; outputs are sampled at falling edges.
module tb_key_debounce_multi;

    logic clk;
    logic rst_n;

    key_debounce_multi_if #(.CH(2)) bus ();

    key_debounce_multi #(
        .CH           (2),
        .TICK_DIV     (4),
        .STABLE_TICKS (3),
        .LONG_TICKS   (5),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    int cyc = 0;
    int n_press [2];
    int n_rel   [2];
    int n_long  [2];
    int t_press [2];
    int t_long  [2];
    int both_press;
    int bad_pulse;
    int bad_excl;
    logic prev_tick;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < 2; c++) begin
            n_press[c] = 0;
            n_rel[c]   = 0;
            n_long[c]  = 0;
            t_press[c] = -1;
            t_long[c]  = -1;
        end
        both_press = 0;
    endtask

    // Advance n cycles, sampling each falling edge and accumulating events.
    task automatic step(input int n);
        logic [1:0] pr, rl, lg;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            pr = bus.key_press;
            rl = bus.key_release;
            lg = bus.key_long;
            for (int c = 0; c < 2; c++) begin
                if (pr[c]) begin n_press[c]++; t_press[c] = cyc; end
                if (rl[c]) n_rel[c]++;
                if (lg[c]) begin n_long[c]++; t_long[c] = cyc; end
            end
            if (pr == 2'b11) both_press++;
            // A pulse is only legal right after an edge that closed a tick cycle.
            if (((pr | rl | lg) != 2'b00) && !prev_tick) bad_pulse++;
            if (((pr & rl) | (pr & lg) | (rl & lg)) != 2'b00) bad_excl++;
            prev_tick = bus.tick_out;
        end
    endtask

    int e;

    initial begin
        bad_pulse = 0;
        bad_excl  = 0;
        prev_tick = 1'b0;
        clear_counts();

        // ---------------- 1. reset with both keys held ----------------
        rst_n = 1'b0;
        bus.key_in = 2'b00;
        step(3);
        check("rst_state",   {30'd0, bus.key_state}, 32'd0);
        check("rst_pulses",  {26'd0, bus.key_press, bus.key_release, bus.key_long}, 32'd0);
        check("rst_tick",    {31'd0, bus.tick_out}, 32'd0);
        check("rst_stab",    {30'd0, dut.stab_cnt[0]}, 32'd0);
        rst_n = 1'b1;
        prev_tick = 1'b0;
        step(2);
        check("tick_early",  {31'd0, bus.tick_out}, 32'd0);
        step(1);
        check("tick_first",  {31'd0, bus.tick_out}, 32'd1);
        step(1);
        check("tick_clear",  {31'd0, bus.tick_out}, 32'd0);
        step(7);
        check("rst_nopress", {30'd0, bus.key_press}, 32'd0);
        check("rst_state11", {30'd0, bus.key_state}, 32'd0);
        step(1);
        check("rst_press",   {30'd0, bus.key_press}, 32'd3);
        check("rst_state",   {30'd0, bus.key_state}, 32'd3);
        bus.key_in = 2'b11;
        step(20);
        check("rst_relstate", {30'd0, bus.key_state}, 32'd0);
        check("rst_rel0",     n_rel[0], 32'd1);
        check("rst_rel1",     n_rel[1], 32'd1);
        check("rst_nolong",   n_long[0] + n_long[1], 32'd0);

        // ---------------- 2. clean press / release on ch0 --------------
        clear_counts();
        bus.key_in[0] = 1'b0;
        e = cyc;
        step(40);
        check("clean_npress", n_press[0], 32'd1);
        check("clean_lat",    {31'd0, ((t_press[0] - e) >= 10) && ((t_press[0] - e) <= 14)}, 32'd1);
        check("clean_state",  {30'd0, bus.key_state}, 32'd1);
        check("clean_ch1",    n_press[1] + n_rel[1] + n_long[1], 32'd0);
        bus.key_in[0] = 1'b1;
        step(20);
        check("clean_nrel",   n_rel[0], 32'd1);
        check("clean_state0", {30'd0, bus.key_state}, 32'd0);
        check("clean_ch1b",   n_press[1] + n_rel[1] + n_long[1], 32'd0);

        // ---------------- 3. bounce rejection ---------------------------
        clear_counts();
        for (int j = 0; j < 10; j++) begin
            bus.key_in[0] = ~bus.key_in[0];
            step(3);
        end
        step(16);
        check("bounce_state", {30'd0, bus.key_state}, 32'd0);
        check("bounce_evts",  n_press[0] + n_rel[0] + n_long[0], 32'd0);

        // ---------------- 4. abort after two ticks ----------------------
        clear_counts();
        bus.key_in[0] = 1'b0;
        step(8);
        bus.key_in[0] = 1'b1;
        step(2);
        check("abort_cnt2",   {30'd0, dut.stab_cnt[0]}, 32'd2);
        step(4);
        check("abort_cnt0",   {30'd0, dut.stab_cnt[0]}, 32'd0);
        step(10);
        check("abort_press",  n_press[0], 32'd0);
        check("abort_state",  {30'd0, bus.key_state}, 32'd0);

        // ---------------- 5. long press ---------------------------------
        clear_counts();
        bus.key_in[0] = 1'b0;
        step(60);
        check("long_npress",  n_press[0], 32'd1);
        check("long_nlong",   n_long[0], 32'd1);
        check("long_delay",   t_long[0] - t_press[0], 32'd20);
        check("long_state",   {30'd0, bus.key_state}, 32'd1);
        bus.key_in[0] = 1'b1;
        step(20);
        check("long_rel",     n_rel[0], 32'd1);
        clear_counts();
        bus.key_in[0] = 1'b0;
        step(16);
        bus.key_in[0] = 1'b1;
        step(24);
        check("short_press",  n_press[0], 32'd1);
        check("short_rel",    n_rel[0], 32'd1);
        check("short_nolong", n_long[0], 32'd0);

        // ---------------- 6. simultaneous press + async reset -----------
        clear_counts();
        bus.key_in = 2'b00;
        step(16);
        check("simul_both",   both_press, 32'd1);
        check("simul_state",  {30'd0, bus.key_state}, 32'd3);
        #3 rst_n = 1'b0;
        #1;
        check("async_state",  {30'd0, bus.key_state}, 32'd0);
        check("async_tick",   {31'd0, bus.tick_out}, 32'd0);
        check("async_stab",   {30'd0, dut.stab_cnt[1]}, 32'd0);
        step(2);
        clear_counts();
        rst_n = 1'b1;
        prev_tick = 1'b0;
        step(11);
        check("rearm_none",   n_press[0] + n_press[1], 32'd0);
        check("rearm_state",  {30'd0, bus.key_state}, 32'd0);
        step(1);
        check("rearm_press",  {30'd0, bus.key_press}, 32'd3);
        step(19);
        check("rearm_nolong", n_long[0] + n_long[1], 32'd0);
        step(1);
        check("rearm_long",   {30'd0, bus.key_long}, 32'd3);
        step(12);
        check("rearm_1long",  n_long[0] + n_long[1], 32'd2);

        // ---------------- pulse rules over the whole run ----------------
        check("pulse_on_tick", bad_pulse, 32'd0);
        check("pulse_excl",    bad_excl, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
Parametrised multi-channel debouncer that supersedes the single-key slow-clock/two-flop debouncer.
- Synchronises each raw key input and qualifies it with a shared tick timebase and per-channel stability counters.
- Provides a debounced level plus one-clock press, release and long-press pulses per channel.
- Sits between board push-buttons and control FSMs (elevator call buttons, menu keys).

Parameters:
CH, 4, number of independent key channels (>=1)
TICK_DIV, 240000, clk cycles per sample tick (>=2); 20 ms at 12 MHz
STABLE_TICKS, 2, consecutive ticks a changed level must hold before acceptance (>=1)
LONG_TICKS, 50, ticks of continuous pressed state before the long-press pulse (>=1); 1 s at default tick
ACTIVE_LOW, 1, 1: raw key reads 0 when pressed; 0: reads 1 when pressed

Ports:
clk  input  1  system clock; single clock domain, all flops rising-edge
rst_n  input  1  asynchronous active-low reset
key_in  input  CH  raw asynchronous key inputs, bit i = channel i
key_state  output  CH  debounced level, 1 = pressed (polarity already normalised)
key_press  output  CH  one-clk pulse on accepted released->pressed transition
key_release  output  CH  one-clk pulse on accepted pressed->released transition
key_long  output  CH  one-clk pulse when pressed state has lasted LONG_TICKS ticks
tick_out  output  1  shared sample tick, one clk wide, for reuse by neighbours

Behaviour:
Reset (rst_n low, async):
- All outputs are 0; tick counter, stability counters and long counters are 0.
- Synchroniser flops take the released level: 1 if ACTIVE_LOW, else 0. No spurious press is generated on reset release.

Tick generator:
- Counter runs 0..TICK_DIV-1, width $clog2(TICK_DIV).
- tick_out = 1 exactly in the cycle where the counter equals TICK_DIV-1; the counter then wraps to 0.
- Period is TICK_DIV clk cycles; the first tick occurs TICK_DIV cycles after reset release.

Synchroniser:
- Two flops per channel sample key_in every clk.
- The normalised sample s[i] is the second flop XOR ACTIVE_LOW, so 1 = pressed.

Per-channel debounce, evaluated only on tick cycles:
- If s[i] == key_state[i]: stability counter cleared to 0.
- If s[i] != key_state[i] and counter < STABLE_TICKS-1: counter increments.
- If s[i] != key_state[i] and counter == STABLE_TICKS-1, at that same edge:
  - key_state[i] toggles and the counter clears.
  - key_press[i] is asserted if the new state is 1, key_release[i] if it is 0, each for exactly one clk.
- Any single tick sample agreeing with the current state aborts the pending change (counter back to 0).
- Counter width is $clog2(STABLE_TICKS+1). It never exceeds STABLE_TICKS-1.
- On non-tick cycles all counters and key_state hold.

Long press:
- The long counter clears whenever key_state[i] is 0, including the edge where the state becomes 1.
- While key_state[i] is 1, it increments on each tick and saturates at LONG_TICKS.
- key_long[i] pulses for one clk at the tick edge where the counter transitions from LONG_TICKS-1 to LONG_TICKS. Exactly one pulse per press, no auto-repeat.
- Release before LONG_TICKS gives no key_long.
- Counter width is $clog2(LONG_TICKS+1).

Latency:
- From key_in settling to the key_press edge: 2 clk (synchroniser) plus the wait to the STABLE_TICKS-th qualifying tick.
- Bounds: min 2 + (STABLE_TICKS-1)*TICK_DIV + 1 clk; max 2 + STABLE_TICKS*TICK_DIV clk.

Concurrency and pulse rules:
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
- key_press, key_release and key_long are mutually exclusive per channel per cycle.
- All pulse outputs are registered and are 0 on every non-tick cycle.

Reset mid-operation:
- An async rst_n assertion immediately clears all outputs and counters and discards pending transitions.
- A key held through reset release is reported as a fresh press after the normal qualification delay.

Test Plan (bench params CH=2, TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=5, ACTIVE_LOW=1):
1. Reset: rst_n=0 with key_in=2'b00 (pressed), then release rst_n -> all outputs 0 during reset; tick_out first high 4 clk after release; ch0/ch1 key_press pulse on the 3rd qualifying tick, key_state=2'b11.
2. Clean press/release ch0: key_in[0] 1->0, held 40 clk, then 0->1 -> one key_press[0] pulse 10..14 clk after the edge; key_state[0]=1; after release, one key_release[0] pulse and key_state[0]=0; ch1 outputs stay 0.
3. Bounce rejection: key_in[0] toggles every 3 clk for 30 clk, then stays 1 -> key_state[0] remains 0; no pulses at any time.
4. Abort: key_in[0] low for exactly 2 ticks (8 clk), then high -> no key_press; stability counter observed back to 0.
5. Long press: key_in[0] held low 60 clk -> key_press[0], then exactly one key_long[0] pulse 5 ticks (20 clk) after key_press; no second pulse while still held; short 12-clk-qualified press with release before 5 ticks -> no key_long.
6. Simultaneous + async reset: both keys pressed in the same clk -> key_press=2'b11 in one cycle; assert rst_n mid-qualification -> outputs 0 asynchronously (before the next clk edge), no pulse after release until a fresh 3-tick qualification.
